// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake body engine: direction encodings,
// FSM state type and default coordinate widths.
package snake_pkg;

    localparam int H_W_DEF = 5;
    localparam int V_W_DEF = 5;

    localparam logic [3:0] DIR_R = 4'b1000;
    localparam logic [3:0] DIR_L = 4'b0100;
    localparam logic [3:0] DIR_U = 4'b0010;
    localparam logic [3:0] DIR_D = 4'b0001;

    // state     | meaning
    // ST_INIT   | writing the initial body, one entry per cycle
    // ST_IDLE   | waiting for step / out_req (or a pending one)
    // ST_MOVE   | new head written, head pointer moved, length updated
    // ST_CHECK  | scanning body 1..length-1 against the new head
    // ST_STREAM | emitting segments head first over valid/ready
    // ST_DEAD   | collided; only streaming and reset are honoured
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_MOVE,
        ST_CHECK,
        ST_STREAM,
        ST_DEAD
    } state_e;

    function automatic logic [3:0] dir_opposite(input logic [3:0] d);
        logic [3:0] o;
        case (d)
            DIR_R:   o = DIR_L;
            DIR_L:   o = DIR_R;
            DIR_U:   o = DIR_D;
            DIR_D:   o = DIR_U;
            default: o = 4'b0000;
        endcase
        return o;
    endfunction

    function automatic logic is_onehot4(input logic [3:0] d);
        return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/snake_ring_buf.sv
// Ring storage for the snake body; entry hp is the head, reads are relative
// to hp with an explicit modulo so MAX_LEN need not be a power of two.
module snake_ring_buf #(
    parameter int MAX_LEN = 64,
    parameter int IDX_W   = 6,
    parameter int D_W     = 10
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [D_W-1:0]   wdata_i,
    input  logic [IDX_W-1:0] hp_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [D_W-1:0]   rdata_o
);

    logic [D_W-1:0] mem_q [MAX_LEN];
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] raddr;

    always_comb begin
        sum = {1'b0, hp_i} + {1'b0, idx_i};
        if (sum >= (IDX_W+1)'(MAX_LEN)) begin
            sum = sum - (IDX_W+1)'(MAX_LEN);
        end
        raddr = sum[IDX_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr];

endmodule

// File: rtl/snake_body_engine.sv
// Snake body store and mover: ring-buffer body, direction filtering, growth,
// wrap/wall handling, serial self-collision scan and valid/ready segment stream.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int H_MAX    = 31,
    parameter int V_MAX    = 23,
    parameter int H_W      = H_W_DEF,
    parameter int V_W      = V_W_DEF,
    parameter int MAX_LEN  = 64,
    parameter int LEN_W    = 7,
    parameter int INIT_LEN = 3,
    parameter int WRAP_EN  = 1
) (
    input  logic             clk,
    input  logic             DLY_RST,
    input  logic             step,
    input  logic [3:0]       way,
    input  logic             grow,
    input  logic             out_req,
    input  logic             seg_rdy,
    output logic             seg_vld,
    output logic [H_W-1:0]   seg_x,
    output logic [V_W-1:0]   seg_y,
    output logic             seg_last,
    output logic [LEN_W-1:0] length,
    output logic             collide,
    output logic             busy
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int D_W   = H_W + V_W;
    localparam logic [H_W-1:0] X0 = H_W'((H_MAX + 1) / 2);
    localparam logic [V_W-1:0] Y0 = V_W'((V_MAX + 1) / 2);
    localparam logic [H_W-1:0] XM = H_W'(H_MAX);
    localparam logic [V_W-1:0] YM = V_W'(V_MAX);

    state_e           state_q, state_d;
    logic [3:0]       dir_q;
    logic [IDX_W-1:0] hp_q;
    logic [LEN_W-1:0] len_q;
    logic [IDX_W-1:0] idx_q;
    logic [H_W-1:0]   hx_q;
    logic [V_W-1:0]   hy_q;
    logic             grow_q;
    logic             collide_q;
    logic             step_pend_q, out_pend_q;
    logic [3:0]       way_pend_q;
    logic             grow_pend_q;

    logic             eff_step, eff_out, eff_grow;
    logic [3:0]       eff_way, dir_nx;
    logic [H_W-1:0]   nx;
    logic [V_W-1:0]   ny;
    logic             off_grid, wall_hit;
    logic [IDX_W-1:0] hp_dec;
    logic             idx_last, init_last, hit;
    logic             busy_int;
    logic             we;
    logic [IDX_W-1:0] waddr;
    logic [D_W-1:0]   wdata, rdata;

    // A step arriving in IDLE wins over a latched one and brings its own way/grow.
    assign eff_step = step | step_pend_q;
    assign eff_out  = out_req | out_pend_q;
    assign eff_way  = step ? way  : way_pend_q;
    assign eff_grow = step ? grow : grow_pend_q;
    assign dir_nx   = (is_onehot4(eff_way) && (eff_way != dir_opposite(dir_q))) ? eff_way : dir_q;

    // U decreases y, D increases y (row 0 is the top of the grid).
    always_comb begin
        nx       = hx_q;
        ny       = hy_q;
        off_grid = 1'b0;
        case (dir_nx)
            DIR_R: if (hx_q == XM) begin nx = '0; off_grid = 1'b1; end else nx = hx_q + 1'b1;
            DIR_L: if (hx_q == '0) begin nx = XM; off_grid = 1'b1; end else nx = hx_q - 1'b1;
            DIR_U: if (hy_q == '0) begin ny = YM; off_grid = 1'b1; end else ny = hy_q - 1'b1;
            DIR_D: if (hy_q == YM) begin ny = '0; off_grid = 1'b1; end else ny = hy_q + 1'b1;
            default: ;
        endcase
        wall_hit = off_grid && (WRAP_EN == 0);
    end

    assign hp_dec    = (hp_q == '0) ? IDX_W'(MAX_LEN - 1) : hp_q - 1'b1;
    assign idx_last  = (LEN_W'(idx_q) == len_q - LEN_W'(1));
    assign init_last = (idx_q == IDX_W'(INIT_LEN - 1));
    assign hit       = (state_q == ST_CHECK) && (rdata == {hx_q, hy_q});

    assign we    = (state_q == ST_INIT) || (state_q == ST_MOVE);
    assign waddr = (state_q == ST_INIT) ? idx_q : hp_dec;
    assign wdata = (state_q == ST_INIT) ? {X0 - H_W'(idx_q), Y0} : {hx_q, hy_q};

    snake_ring_buf #(
        .MAX_LEN (MAX_LEN),
        .IDX_W   (IDX_W),
        .D_W     (D_W)
    ) u_ring (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .hp_i    (hp_q),
        .idx_i   (idx_q),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or negedge DLY_RST) begin
        if (!DLY_RST) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   if (init_last) state_d = ST_IDLE;
            ST_IDLE: begin
                if (eff_step)     state_d = wall_hit ? ST_DEAD : ST_MOVE;
                else if (eff_out) state_d = ST_STREAM;
            end
            ST_MOVE:   state_d = ST_CHECK;
            ST_CHECK: begin
                if (hit)           state_d = ST_DEAD;
                else if (idx_last) state_d = ST_IDLE;
            end
            ST_STREAM: if (seg_rdy && idx_last) state_d = collide_q ? ST_DEAD : ST_IDLE;
            ST_DEAD:   if (eff_out) state_d = ST_STREAM;
            default:   state_d = ST_INIT;
        endcase
    end

    always_comb begin
        busy_int = (state_q != ST_IDLE) && (state_q != ST_DEAD);
        seg_vld  = (state_q == ST_STREAM);
        seg_last = seg_vld && idx_last;
        seg_x    = seg_vld ? rdata[D_W-1:V_W] : '0;
        seg_y    = seg_vld ? rdata[V_W-1:0]   : '0;
        busy     = busy_int;
        length   = len_q;
        collide  = collide_q;
    end

    always_ff @(posedge clk or negedge DLY_RST) begin
        if (!DLY_RST) begin
            dir_q       <= DIR_R;
            hp_q        <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            hx_q        <= X0;
            hy_q        <= Y0;
            grow_q      <= 1'b0;
            collide_q   <= 1'b0;
            step_pend_q <= 1'b0;
            out_pend_q  <= 1'b0;
            way_pend_q  <= 4'b0000;
            grow_pend_q <= 1'b0;
        end else begin
            if (busy_int && step) begin
                step_pend_q <= 1'b1;
                way_pend_q  <= way;
                grow_pend_q <= grow;
            end
            if (busy_int && out_req) begin
                out_pend_q <= 1'b1;
            end
            case (state_q)
                ST_INIT: begin
                    idx_q <= init_last ? '0 : idx_q + 1'b1;
                    if (init_last) len_q <= LEN_W'(INIT_LEN);
                end
                ST_IDLE: begin
                    if (eff_step) begin
                        dir_q       <= dir_nx;
                        step_pend_q <= 1'b0;
                        out_pend_q  <= eff_out;
                        if (wall_hit) begin
                            collide_q <= 1'b1;
                        end else begin
                            hx_q   <= nx;
                            hy_q   <= ny;
                            grow_q <= eff_grow;
                        end
                    end else if (eff_out) begin
                        out_pend_q <= 1'b0;
                        idx_q      <= '0;
                    end
                end
                ST_MOVE: begin
                    hp_q  <= hp_dec;
                    idx_q <= IDX_W'(1);
                    if (grow_q && (len_q < LEN_W'(MAX_LEN))) len_q <= len_q + 1'b1;
                end
                ST_CHECK: begin
                    idx_q <= idx_q + 1'b1;
                    if (hit) collide_q <= 1'b1;
                end
                ST_STREAM: begin
                    if (seg_rdy) idx_q <= idx_q + 1'b1;
                end
                ST_DEAD: begin
                    step_pend_q <= 1'b0;
                    if (eff_out) begin
                        out_pend_q <= 1'b0;
                        idx_q      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body_engine.sv
// Self-checking bench for snake_body_engine: a queue-based snake model for the
// wrapping instance, plus directed literal checks on a wall-mode instance.
module tb_snake_body_engine;

    localparam logic [3:0] R = 4'b1000;
    localparam logic [3:0] L = 4'b0100;
    localparam logic [3:0] U = 4'b0010;
    localparam logic [3:0] D = 4'b0001;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
    } pt_t;

    logic       clk = 1'b0;
    logic       dly_rst = 1'b0;
    logic       step = 1'b0, grow = 1'b0, out_req = 1'b0, seg_rdy = 1'b1;
    logic [3:0] way = 4'b0000;
    logic       seg_vld, seg_last, collide, busy;
    logic [4:0] seg_x, seg_y;
    logic [6:0] length;

    logic       step_b = 1'b0, out_req_b = 1'b0;
    logic [3:0] way_b = 4'b0000;
    logic       seg_vld_b, seg_last_b, collide_b, busy_b;
    logic [4:0] seg_x_b, seg_y_b;
    logic [6:0] length_b;

    int n_tests = 0;
    int n_fail  = 0;

    pt_t        body[$];
    pt_t        snap[$];
    logic [3:0] m_dir;
    int         m_len;
    bit         m_dead;
    bit         m_collide;
    int         m_hit;
    int         k;
    bit         stream_done;
    bit         prev_stall;
    logic [4:0] prev_x, prev_y;

    always #5 clk = ~clk;

    snake_body_engine #(.WRAP_EN(1)) u_dut (
        .clk(clk), .DLY_RST(dly_rst), .step(step), .way(way), .grow(grow),
        .out_req(out_req), .seg_rdy(seg_rdy), .seg_vld(seg_vld), .seg_x(seg_x),
        .seg_y(seg_y), .seg_last(seg_last), .length(length), .collide(collide), .busy(busy)
    );

    snake_body_engine #(.WRAP_EN(0)) u_wall (
        .clk(clk), .DLY_RST(dly_rst), .step(step_b), .way(way_b), .grow(1'b0),
        .out_req(out_req_b), .seg_rdy(1'b1), .seg_vld(seg_vld_b), .seg_x(seg_x_b),
        .seg_y(seg_y_b), .seg_last(seg_last_b), .length(length_b), .collide(collide_b), .busy(busy_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        pt_t p;
        body.delete();
        for (int i = 0; i < 3; i++) begin
            p.x = 5'(16 - i);
            p.y = 5'd12;
            body.push_back(p);
        end
        m_dir = R; m_len = 3; m_dead = 0; m_collide = 0; m_hit = -1;
    endfunction

    function automatic void model_step(input logic [3:0] w, input bit g);
        logic [3:0] opp;
        int nx, ny;
        pt_t p;
        m_hit = -1;
        if (m_dead) return;
        opp = (m_dir == R) ? L : (m_dir == L) ? R : (m_dir == U) ? D : U;
        if ($countones(w) == 1 && w != opp) m_dir = w;
        nx = int'(body[0].x);
        ny = int'(body[0].y);
        if (m_dir == R) nx++;
        else if (m_dir == L) nx--;
        else if (m_dir == U) ny--;
        else ny++;
        p.x = 5'((nx + 32) % 32);
        p.y = 5'((ny + 24) % 24);
        body.push_front(p);
        if (g && m_len < 64) m_len++;
        while (body.size() > m_len) void'(body.pop_back());
        for (int i = 1; i < m_len; i++) begin
            if (body[i] == body[0]) begin
                m_hit = i;
                break;
            end
        end
        if (m_hit > 0) begin
            m_dead = 1;
            m_collide = 1;
        end
    endfunction

    // Stream monitor: every accepted segment against the snapshot, and data held while stalled.
    always @(negedge clk) begin
        if (dly_rst) begin
            if (prev_stall) begin
                chk("hold_vld", int'(seg_vld), 1);
                chk("hold_x", int'(seg_x), int'(prev_x));
                chk("hold_y", int'(seg_y), int'(prev_y));
            end
            if (seg_vld && seg_rdy) begin
                if (k < snap.size()) begin
                    chk("seg_x", int'(seg_x), int'(snap[k].x));
                    chk("seg_y", int'(seg_y), int'(snap[k].y));
                    chk("seg_last", int'(seg_last), int'(k == snap.size() - 1));
                end else begin
                    chk("seg_count", k, snap.size() - 1);
                end
                k++;
                if (k == snap.size()) stream_done = 1;
            end
            prev_stall = seg_vld && !seg_rdy;
            prev_x = seg_x;
            prev_y = seg_y;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic do_reset();
        dly_rst = 1'b0;
        step = 0; grow = 0; out_req = 0; seg_rdy = 1; way = 0;
        repeat (2) @(negedge clk);
        chk("rst_seg_vld", int'(seg_vld), 0);
        chk("rst_seg_x", int'(seg_x), 0);
        chk("rst_seg_y", int'(seg_y), 0);
        chk("rst_seg_last", int'(seg_last), 0);
        chk("rst_length", int'(length), 0);
        chk("rst_collide", int'(collide), 0);
        chk("rst_busy", int'(busy), 1);
        @(posedge clk); #1;
        dly_rst = 1'b1;
        model_reset();
        wait_idle();
        chk("init_length", int'(length), 3);
    endtask

    task automatic step_a(input logic [3:0] w, input bit g);
        int cnt = 0;
        int exp_busy;
        bit was_dead = m_dead;
        wait_idle();
        @(posedge clk); #1;
        step = 1; way = w; grow = g;
        @(posedge clk); #1;
        step = 0; way = 0; grow = 0;
        model_step(w, g);
        exp_busy = was_dead ? 0 : (m_hit > 0) ? 1 + m_hit : m_len;
        @(negedge clk);
        while (busy && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        chk("busy_cycles", cnt, exp_busy);
        chk("length", int'(length), m_len);
        chk("collide", int'(collide), int'(m_collide));
    endtask

    task automatic stream_a(input bit toggle, input int step_at, input logic [3:0] sw);
        int cyc = 0;
        int n = 0;
        wait_idle();
        snap = body;
        k = 0;
        stream_done = 0;
        @(posedge clk); #1;
        out_req = 1; seg_rdy = 1;
        @(posedge clk); #1;
        out_req = 0;
        while (!stream_done && cyc < 400) begin
            if (toggle) seg_rdy = !seg_rdy;
            step = (cyc == step_at);
            way  = (cyc == step_at) ? sw : 4'b0000;
            if (cyc == step_at) model_step(sw, 1'b0);
            @(posedge clk); #1;
            cyc++;
        end
        step = 0; way = 0; seg_rdy = 1;
        chk("stream_done", int'(stream_done), 1);
        if (step_at >= 0) begin
            @(negedge clk);
            while (!busy && n < 4) begin
                @(negedge clk);
                n++;
            end
            chk("pending_step_served", int'(busy), 1);
            wait_idle();
            chk("length_after_pending", int'(length), m_len);
            chk("collide_after_pending", int'(collide), int'(m_collide));
        end
    endtask

    task automatic step_b_pulse(input logic [3:0] w);
        int n = 0;
        @(posedge clk); #1;
        step_b = 1; way_b = w;
        @(posedge clk); #1;
        step_b = 0; way_b = 0;
        @(negedge clk);
        while (busy_b && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        do_reset();
        chk("rst_b_length", int'(length_b), 3);

        // Wall instance: walk to x=31, then one more R must collide without moving.
        for (int i = 0; i < 15; i++) step_b_pulse(R);
        chk("wall_pre_collide", int'(collide_b), 0);
        step_b_pulse(R);
        chk("wall_collide", int'(collide_b), 1);
        chk("wall_length", int'(length_b), 3);
        chk("wall_busy", int'(busy_b), 0);
        step_b_pulse(R);
        chk("wall_dead_length", int'(length_b), 3);
        chk("wall_dead_collide", int'(collide_b), 1);
        @(posedge clk); #1;
        out_req_b = 1;
        @(posedge clk); #1;
        out_req_b = 0;
        @(negedge clk);
        chk("wall_head_vld", int'(seg_vld_b), 1);
        chk("wall_head_x", int'(seg_x_b), 31);
        chk("wall_head_y", int'(seg_y_b), 12);

        // Initial body stream.
        chk("model_init_x0", int'(body[0].x), 16);
        chk("model_init_x2", int'(body[2].x), 14);
        stream_a(1'b0, -1, 4'b0000);
        chk("init_stream_count", k, 3);

        // Reversal and non-one-hot ways keep R; then wrap at the right edge.
        step_a(L, 1'b0);
        step_a(4'b0110, 1'b0);
        chk("model_rev_x", int'(body[0].x), 18);
        for (int i = 0; i < 13; i++) step_a(R, 1'b0);
        chk("model_edge_x", int'(body[0].x), 31);
        step_a(R, 1'b0);
        chk("model_wrap_x", int'(body[0].x), 0);
        chk("model_wrap_y", int'(body[0].y), 12);
        stream_a(1'b1, -1, 4'b0000);

        // Step arriving mid-stream is held until the stream ends.
        stream_a(1'b1, 2, D);
        chk("model_pending_y", int'(body[0].y), 13);
        stream_a(1'b0, -1, 4'b0000);

        // Self collision: grow to 5, then U, L, D.
        do_reset();
        step_a(R, 1'b1);
        step_a(R, 1'b1);
        step_a(U, 1'b0);
        step_a(L, 1'b0);
        step_a(D, 1'b0);
        chk("model_self_collide", int'(m_collide), 1);
        chk("model_hit_index", m_hit, 4);
        step_a(R, 1'b0);
        chk("model_dead_head_x", int'(body[0].x), 17);
        stream_a(1'b1, -1, 4'b0000);

        // Serpentine growth to the maximum length, then one more grow.
        do_reset();
        for (int i = 0; i < 15; i++) step_a(R, 1'b1);
        step_a(D, 1'b1);
        for (int i = 0; i < 30; i++) step_a(L, 1'b1);
        step_a(D, 1'b1);
        for (int i = 0; i < 14; i++) step_a(R, 1'b1);
        chk("model_max_len", m_len, 64);
        step_a(R, 1'b1);
        chk("model_capped_len", m_len, 64);
        chk("model_tail_x", int'(body[63].x), 15);
        stream_a(1'b0, -1, 4'b0000);
        chk("max_stream_count", k, 64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
